// File: rtl/rule90_snapshot_streamer.sv
// Rule 90 snapshot streamer: freezes one automaton generation on capture and
// streams it as WORD_W-bit beats while accumulating the live-cell count.

module r90_popcnt #(
  parameter  int W  = 32,
  localparam int OW = $clog2(W+1)
) (
  input  logic [W-1:0]  d,
  output logic [OW-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + OW'(d[i]);
  end
endmodule

module rule90_snapshot_streamer #(
  parameter  int STATE_W = 512,
  parameter  int WORD_W  = 32,
  localparam int NWORDS  = STATE_W / WORD_W,
  localparam int IW      = (NWORDS > 1) ? $clog2(NWORDS) : 1,
  localparam int PW      = $clog2(STATE_W+1),
  localparam int CW      = $clog2(WORD_W+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STATE_W-1:0] state_in,
  input  logic              capture,
  output logic              busy,
  output logic              capture_drop,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [IW-1:0]     out_index,
  output logic [PW-1:0]     pop_count,
  output logic              pop_valid,
  output logic [7:0]        frame_count
);
  typedef enum logic {IDLE, STREAM} st_t;

  st_t                            st;
  logic [NWORDS-1:0][WORD_W-1:0]  snap;
  logic [PW-1:0]                  acc;
  logic [CW-1:0]                  wpc;

  // Word select straight off the frozen snapshot; index only moves on handshake.
  assign out_data = snap[out_index];

  r90_popcnt #(.W(WORD_W)) u_pc (.d(out_data), .cnt(wpc));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= IDLE;
      snap         <= '0;
      acc          <= '0;
      out_index    <= '0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      capture_drop <= 1'b0;
      pop_count    <= '0;
      pop_valid    <= 1'b0;
      frame_count  <= '0;
    end else begin
      // busy is still high on the final-beat edge, so a capture there drops too.
      capture_drop <= capture && busy;
      case (st)
        IDLE: begin
          if (capture) begin
            snap      <= state_in;
            out_index <= '0;
            acc       <= '0;
            pop_valid <= 1'b0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_last  <= (NWORDS == 1);
            st        <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              pop_count   <= acc + PW'(wpc);
              pop_valid   <= 1'b1;
              frame_count <= frame_count + 8'd1;
              busy        <= 1'b0;
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              st          <= IDLE;
            end else begin
              acc       <= acc + PW'(wpc);
              out_index <= out_index + IW'(1);
              out_last  <= (out_index == IW'(NWORDS-2));
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rule90_snapshot_streamer.sv
// Scoreboard bench: each accepted capture records its frame as a word list and
// a whole-frame population, and every cycle the outputs are compared with it.

module tb_rule90_snapshot_streamer;
  localparam int STATE_W = 512;
  localparam int WORD_W  = 32;
  localparam int NWORDS  = STATE_W / WORD_W;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [STATE_W-1:0] state_in = '0;
  logic               capture = 1'b0;
  logic               busy, capture_drop, out_valid, out_ready, out_last, pop_valid;
  logic [WORD_W-1:0]  out_data;
  logic [3:0]         out_index;
  logic [9:0]         pop_count;
  logic [7:0]         frame_count;

  int checks = 0;
  int failures = 0;

  // reference model
  bit                 m_busy = 0, m_pv = 0, m_drop = 0;
  logic [WORD_W-1:0]  m_words [NWORDS];
  logic [STATE_W-1:0] m_frame = '0;
  int                 m_beat = 0, m_pop = 0, m_fc = 0;

  rule90_snapshot_streamer dut (
    .clk(clk), .reset(reset), .state_in(state_in), .capture(capture),
    .busy(busy), .capture_drop(capture_drop), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_index(out_index), .pop_count(pop_count), .pop_valid(pop_valid),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("valid", 32'(out_valid), 32'(m_busy));
    chk("drop", 32'(capture_drop), 32'(m_drop));
    chk("fcount", 32'(frame_count), 32'(m_fc));
    chk("pvalid", 32'(pop_valid), 32'(m_pv));
    chk("pop", 32'(pop_count), 32'(m_pop));
    if (m_busy) begin
      chk("data", out_data, m_words[m_beat]);
      chk("index", 32'(out_index), 32'(m_beat));
      chk("last", 32'(out_last), 32'(m_beat == NWORDS-1));
    end
  endtask

  task automatic cycle(input bit cap, input bit rdy);
    capture = cap;
    out_ready = rdy;
    @(posedge clk);
    m_drop = cap && m_busy;
    if (!m_busy) begin
      if (cap) begin
        m_frame = state_in;
        for (int w = 0; w < NWORDS; w++) m_words[w] = state_in[w*WORD_W +: WORD_W];
        m_beat = 0;
        m_busy = 1;
        m_pv = 0;
      end
    end else if (rdy) begin
      if (m_beat == NWORDS-1) begin
        m_busy = 0;
        m_pop = $countones(m_frame);
        m_pv = 1;
        m_fc = (m_fc + 1) % 256;
      end else begin
        m_beat++;
      end
    end
    #1;
    chk_all();
  endtask

  task automatic run_frame(input logic [STATE_W-1:0] s);
    state_in = s;
    cycle(1, 1);
    for (int n = 0; n < 64 && m_busy; n++) cycle(0, 1);
    chk("frame_done", 32'(busy), 32'd0);
  endtask

  task automatic do_reset;
    capture = 0;
    reset = 1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_pop", 32'(pop_count), 32'd0);
    chk("rst_pvalid", 32'(pop_valid), 32'd0);
    chk("rst_fcount", 32'(frame_count), 32'd0);
    chk("rst_drop", 32'(capture_drop), 32'd0);
    m_busy = 0; m_pv = 0; m_drop = 0; m_beat = 0; m_pop = 0; m_fc = 0;
    #1 reset = 0;
  endtask

  function automatic logic [STATE_W-1:0] rnd_state();
    logic [STATE_W-1:0] s;
    for (int w = 0; w < NWORDS; w++) s[w*WORD_W +: WORD_W] = $urandom;
    return s;
  endfunction

  initial begin
    out_ready = 1'b0;
    #12;
    do_reset();

    // 1: small known value, first beat one clock after capture
    state_in = 512'd86459384;
    cycle(1, 1);
    chk("t1_w0", out_data, 32'h052743F8);
    for (int n = 0; n < 64 && m_busy; n++) cycle(0, 1);
    chk("t1_pop", 32'(pop_count), 32'd14);
    chk("t1_fc", 32'(frame_count), 32'd1);
    chk("t1_pv", 32'(pop_valid), 32'd1);

    // 2: all ones
    run_frame({STATE_W{1'b1}});
    chk("t2_pop", 32'(pop_count), 32'd512);
    chk("t2_fc", 32'(frame_count), 32'd2);

    // 3: backpressure at index 5
    state_in = {16{32'hAAAAAAAA}};
    cycle(1, 1);
    while (m_busy && m_beat != 5) cycle(0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0);
      chk("t3_hold_data", out_data, 32'hAAAAAAAA);
      chk("t3_hold_idx", 32'(out_index), 32'd5);
    end
    for (int n = 0; n < 64 && m_busy; n++) cycle(0, 1);
    chk("t3_pop", 32'(pop_count), 32'd256);

    // 4: capture during stream with changed input, plus capture on final edge
    state_in = rnd_state();
    cycle(1, 1);
    while (m_busy && m_beat != 3) cycle(0, 1);
    state_in = '0;
    cycle(1, 1);
    chk("t4_drop", 32'(capture_drop), 32'd1);
    cycle(0, 1);
    chk("t4_drop_end", 32'(capture_drop), 32'd0);
    while (m_busy && m_beat != NWORDS-1) cycle(0, 1);
    cycle(1, 1);
    chk("t4_lastdrop", 32'(capture_drop), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_fc", 32'(frame_count), 32'd4);
    cycle(0, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) state_in = rnd_state();
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end

    // 5: reset mid-frame
    for (int n = 0; n < 64 && m_busy; n++) cycle(0, 1);
    state_in = rnd_state();
    cycle(1, 1);
    while (m_busy && m_beat != 7) cycle(0, 1);
    do_reset();
    run_frame(512'd86459384);
    chk("t5_pop", 32'(pop_count), 32'd14);
    chk("t5_fc", 32'(frame_count), 32'd1);

    // 6: frame counter wrap
    @(posedge clk); #1;
    do_reset();
    for (int f = 0; f < 256; f++) run_frame('0);
    chk("t6_fc", 32'(frame_count), 32'd0);
    chk("t6_pop", 32'(pop_count), 32'd0);
    chk("t6_pv", 32'(pop_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
